// File: rtl/joy_scan_sequencer.sv
// rtl/joy_scan_sequencer.sv - serial joystick chain scan sequencer
`timescale 1ns/1ps
module joy_scan_sequencer #(
  parameter int CLK_DIV   = 16,
  parameter int NBITS     = 24,
  parameter int FRAME_GAP = 4,
  parameter int FREE_RUN  = 1
) (
  input  logic             clk,
  input  logic             clock_locked,
  input  logic             scan_en,
  input  logic             scan_req,
  input  logic             joy_data,
  output logic             joy_clk,
  output logic             joy_load_n,
  output logic [NBITS-1:0] frame_o,
  output logic             frame_valid,
  output logic             frame_changed,
  output logic             busy
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(NBITS + 1);
  localparam int GAP_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_COMMIT,
    S_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               joy_clk_q, joy_clk_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               req_q, req_d;
  logic [NBITS-1:0]   shreg_q, shreg_d;
  logic [NBITS-1:0]   frame_q, frame_d;
  logic               valid_q, valid_d;
  logic               changed_q, changed_d;
  logic               load_n_q, load_n_d;
  logic               busy_q, busy_d;

  logic wrap;
  logic rise_tick;
  logic fall_tick;

  always_comb begin
    wrap      = (div_q == DIV_W'(CLK_DIV - 1));
    div_d     = wrap ? '0 : div_q + 1'b1;
    joy_clk_d = wrap ? ~joy_clk_q : joy_clk_q;
    rise_tick = wrap & ~joy_clk_q;
    fall_tick = wrap & joy_clk_q;
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    shreg_d   = shreg_q;
    frame_d   = frame_q;
    valid_d   = 1'b0;
    changed_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (fall_tick && scan_en && ((FREE_RUN != 0) || req_q)) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (fall_tick) begin
          state_d   = S_SHIFT;
          bit_cnt_d = '0;
        end
      end
      S_SHIFT: begin
        // Leave as soon as the last sample is in; do not wait for another tick.
        if (bit_cnt_q == BIT_W'(NBITS)) begin
          state_d = S_COMMIT;
        end else if (rise_tick) begin
          shreg_d   = {shreg_q[NBITS-2:0], joy_data};
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      S_COMMIT: begin
        frame_d   = shreg_q;
        valid_d   = 1'b1;
        changed_d = (shreg_q != frame_q);
        gap_cnt_d = '0;
        state_d   = S_GAP;
      end
      S_GAP: begin
        if (FRAME_GAP == 0) begin
          state_d = S_IDLE;
        end else if (fall_tick) begin
          if (gap_cnt_q == GAP_W'(FRAME_GAP - 1)) begin
            gap_cnt_d = '0;
            state_d   = S_IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A request arriving on the same edge as LOAD entry stays pending.
  always_comb begin
    req_d = req_q;
    if (FREE_RUN != 0) begin
      req_d = 1'b0;
    end else begin
      if ((state_q == S_IDLE) && (state_d == S_LOAD)) begin
        req_d = 1'b0;
      end
      if (scan_req) begin
        req_d = 1'b1;
      end
    end
  end

  always_comb begin
    load_n_d = (state_d != S_LOAD);
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge clock_locked) begin
    if (!clock_locked) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      joy_clk_q <= 1'b0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      req_q     <= 1'b0;
      shreg_q   <= '1;
      frame_q   <= '1;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
      load_n_q  <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      joy_clk_q <= joy_clk_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      req_q     <= req_d;
      shreg_q   <= shreg_d;
      frame_q   <= frame_d;
      valid_q   <= valid_d;
      changed_q <= changed_d;
      load_n_q  <= load_n_d;
      busy_q    <= busy_d;
    end
  end

  assign joy_clk       = joy_clk_q;
  assign joy_load_n    = load_n_q;
  assign frame_o       = frame_q;
  assign frame_valid   = valid_q;
  assign frame_changed = changed_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_joy_scan_sequencer.sv
// tb/tb_joy_scan_sequencer.sv - scoreboard bench for joy_scan_sequencer
`timescale 1ns/1ps
module tb_joy_scan_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Instance A: free-run, 8 bits, gap 2
  logic       a_rst_n = 1'b0, a_en = 1'b0, a_req = 1'b0, a_data;
  logic       a_jclk, a_load_n, a_valid, a_changed, a_busy;
  logic [7:0] a_frame, a_chain_val = 8'hFF, a_sr = 8'hFF;
  joy_scan_sequencer #(.CLK_DIV(2), .NBITS(8), .FRAME_GAP(2), .FREE_RUN(1)) dut_a (
    .clk(clk), .clock_locked(a_rst_n), .scan_en(a_en), .scan_req(a_req), .joy_data(a_data),
    .joy_clk(a_jclk), .joy_load_n(a_load_n), .frame_o(a_frame), .frame_valid(a_valid),
    .frame_changed(a_changed), .busy(a_busy));

  // Instance B: request-driven
  logic       b_rst_n = 1'b0, b_en = 1'b0, b_req = 1'b0, b_data;
  logic       b_jclk, b_load_n, b_valid, b_changed, b_busy;
  logic [7:0] b_frame, b_chain_val = 8'h81, b_sr = 8'hFF;
  joy_scan_sequencer #(.CLK_DIV(2), .NBITS(8), .FRAME_GAP(2), .FREE_RUN(0)) dut_b (
    .clk(clk), .clock_locked(b_rst_n), .scan_en(b_en), .scan_req(b_req), .joy_data(b_data),
    .joy_clk(b_jclk), .joy_load_n(b_load_n), .frame_o(b_frame), .frame_valid(b_valid),
    .frame_changed(b_changed), .busy(b_busy));

  // Instance C: 24 bits, back-to-back
  logic        c_rst_n = 1'b0, c_en = 1'b0, c_req = 1'b0, c_data;
  logic        c_jclk, c_load_n, c_valid, c_changed, c_busy;
  logic [23:0] c_frame, c_chain_val = 24'hFFFFFF, c_sr = 24'hFFFFFF;
  joy_scan_sequencer #(.CLK_DIV(2), .NBITS(24), .FRAME_GAP(0), .FREE_RUN(1)) dut_c (
    .clk(clk), .clock_locked(c_rst_n), .scan_en(c_en), .scan_req(c_req), .joy_data(c_data),
    .joy_clk(c_jclk), .joy_load_n(c_load_n), .frame_o(c_frame), .frame_valid(c_valid),
    .frame_changed(c_changed), .busy(c_busy));

  // '165-style chains: parallel load while load_n low, shift on rising chain clock
  always @(negedge a_load_n or posedge a_jclk)
    if (!a_load_n) a_sr = a_chain_val; else a_sr = {a_sr[6:0], 1'b0};
  always @(negedge b_load_n or posedge b_jclk)
    if (!b_load_n) b_sr = b_chain_val; else b_sr = {b_sr[6:0], 1'b0};
  always @(negedge c_load_n or posedge c_jclk)
    if (!c_load_n) c_sr = c_chain_val; else c_sr = {c_sr[22:0], 1'b0};
  assign a_data = a_sr[7];
  assign b_data = b_sr[7];
  assign c_data = c_sr[23];

  logic [7:0]  a_q[$];
  logic [23:0] c_q[$];
  logic [7:0]  a_prev = 8'hFF;
  logic [23:0] c_prev = 24'hFFFFFF;
  int a_frames = 0, a_loads = 0, a_rises = 0, a_last_load = -1, a_spacing = 0, a_last_tog = -1;
  int b_frames = 0, b_loads = 0;
  int c_frames = 0, c_loads = 0, c_last_load = -1, c_spacing = 0;
  logic a_valid_d1 = 1'b0;

  always @(negedge a_load_n) begin
    a_q.push_back(a_chain_val);
    a_loads++;
    if (a_last_load >= 0) a_spacing = cyc - a_last_load;
    a_last_load = cyc;
  end
  always @(posedge a_load_n) if (a_rst_n && a_last_load >= 0) check("a_load_width", cyc - a_last_load, 4);
  always @(posedge a_jclk) a_rises++;
  always @(a_jclk) begin
    if (a_rst_n && a_last_tog >= 0) check("a_half_period", cyc - a_last_tog, 2);
    a_last_tog = a_rst_n ? cyc : -1;
  end
  always @(negedge a_rst_n) begin
    a_q.delete();
    a_prev = 8'hFF;
  end

  always @(negedge c_load_n) begin
    c_q.push_back(c_chain_val);
    c_loads++;
    if (c_last_load >= 0) c_spacing = cyc - c_last_load;
    c_last_load = cyc;
  end
  always @(negedge b_load_n) b_loads++;

  always @(negedge clk) begin
    logic [7:0]  ea;
    logic [23:0] ec;
    if (a_valid) begin
      a_frames++;
      check("a_pulse_width", a_valid_d1, 0);
      check("a_sb_nonempty", a_q.size() != 0, 1);
      if (a_q.size() != 0) begin
        ea = a_q.pop_front();
        check("a_frame", a_frame, ea);
        check("a_changed", a_changed, ea != a_prev);
        a_prev = ea;
      end
    end else if (a_changed) begin
      check("a_changed_without_valid", a_changed, 0);
    end
    a_valid_d1 = a_valid;
    if (c_valid) begin
      c_frames++;
      check("c_sb_nonempty", c_q.size() != 0, 1);
      if (c_q.size() != 0) begin
        ec = c_q.pop_front();
        check("c_frame", c_frame, ec);
        check("c_changed", c_changed, ec != c_prev);
        c_prev = ec;
      end
    end
    if (b_valid) begin
      b_frames++;
      check("b_frame", b_frame, b_chain_val);
    end
  end

  function automatic int ctr(input int id);
    case (id)
      0: return a_frames;
      1: return a_loads;
      2: return a_rises;
      3: return b_frames;
      4: return b_loads;
      5: return c_frames;
      default: return 0;
    endcase
  endfunction

  task automatic wait_ctr(input int id, input int n, input int budget, input string tag);
    int start = ctr(id);
    int k = 0;
    while ((ctr(id) - start < n) && (k < budget)) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_timeout"}, (ctr(id) - start >= n), 1);
  endtask

  task automatic pulse_b_req();
    @(negedge clk);
    b_req = 1'b1;
    @(negedge clk);
    b_req = 1'b0;
  endtask

  initial begin
    int n0;
    repeat (3) @(negedge clk);
    check("rst_jclk", a_jclk, 0);
    check("rst_load_n", a_load_n, 1);
    check("rst_frame", a_frame, 8'hFF);
    check("rst_valid", a_valid, 0);
    check("rst_changed", a_changed, 0);
    check("rst_busy", a_busy, 0);

    // Test 1: first frame after reset
    a_chain_val = 8'hA5;
    a_en = 1'b1;
    a_rst_n = 1'b1;
    wait_ctr(0, 1, 200, "t1_frame");

    // Test 2: static chain, three frames
    a_chain_val = 8'h3C;
    wait_ctr(0, 3, 400, "t2_frames");
    check("t2_load_spacing", a_spacing, 48);

    // Test 4: drop scan_en at bit 4
    a_chain_val = 8'h5A;
    wait_ctr(1, 1, 100, "t4_load");
    wait_ctr(2, 5, 100, "t4_bit4");
    a_en = 1'b0;
    wait_ctr(0, 1, 200, "t4_publish");
    n0 = a_loads;
    repeat (400) @(negedge clk);
    check("t4_no_load", a_loads - n0, 0);
    check("t4_busy", a_busy, 0);

    // Test 5: reset at bit 5 with chain 00
    a_chain_val = 8'h00;
    a_en = 1'b1;
    wait_ctr(1, 1, 100, "t5_load");
    wait_ctr(2, 6, 100, "t5_bit5");
    #2 a_rst_n = 1'b0;
    #1;
    check("t5_jclk", a_jclk, 0);
    check("t5_load_n", a_load_n, 1);
    check("t5_frame", a_frame, 8'hFF);
    check("t5_valid", a_valid, 0);
    check("t5_busy", a_busy, 0);
    repeat (3) @(negedge clk);
    a_rst_n = 1'b1;
    wait_ctr(0, 1, 200, "t5_frame_after");
    a_en = 1'b0;
    repeat (100) @(negedge clk);
    check("a_sb_empty", a_q.size(), 0);

    // Test 3: request mode, coalesced requests
    b_en = 1'b1;
    b_rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("t3_idle_busy", b_busy, 0);
    check("t3_idle_loads", b_loads, 0);
    pulse_b_req();
    wait_ctr(4, 1, 50, "t3_load1");
    repeat (8) @(negedge clk);
    check("t3_busy_mid", b_busy, 1);
    pulse_b_req();
    repeat (3) @(negedge clk);
    pulse_b_req();
    repeat (3) @(negedge clk);
    pulse_b_req();
    wait_ctr(3, 2, 400, "t3_frames");
    repeat (200) @(negedge clk);
    check("t3_loads", b_loads, 2);
    check("t3_frame_count", b_frames, 2);
    check("t3_busy_end", b_busy, 0);
    check("t3_load_n_end", b_load_n, 1);

    // Test 6: 24-bit back-to-back, changing data
    c_chain_val = 24'h800001;
    c_en = 1'b1;
    c_rst_n = 1'b1;
    wait_ctr(5, 1, 300, "t6_f1");
    check("t6_msb", c_frame[23], 1);
    wait_ctr(5, 1, 300, "t6_f2");
    c_chain_val = 24'h123456;
    wait_ctr(5, 1, 300, "t6_f3");
    c_chain_val = 24'h7FFFFE;
    wait_ctr(5, 1, 300, "t6_f4");
    check("t6_spacing", c_spacing, 104);
    c_en = 1'b0;
    repeat (300) @(negedge clk);
    check("c_sb_empty", c_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
